// File: rtl/dma_lane_sequencer.sv
// Packs a valid/ready stream of lane payloads into DMA port words for the lane
// demultiplexer, one frame of up to NUM_LANES lanes per start command.
module dma_lane_sequencer #(
    parameter int NUM_LANES = 18,
    parameter int PAY_W     = 25,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] lane_count,
    input  logic             abort,
    input  logic             s_valid,
    input  logic [PAY_W-1:0] s_data,
    output logic             s_ready,
    output logic [31:0]      DMAport,
    output logic             dma_valid,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Index 31 addresses no lane, so the demultiplexer ignores this word.
    localparam logic [31:0]      IDLE_WORD = 32'h0000_001F;
    localparam logic [IDX_W-1:0] FULL_CNT  = IDX_W'(NUM_LANES);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic             xfer_s;
    logic             first_s;
    logic             last_s;
    logic [31:0]      word_s;

    function automatic logic [IDX_W-1:0] clamp_count(input logic [IDX_W-1:0] req);
        if ((req == {IDX_W{1'b0}}) || (req > FULL_CNT)) begin
            return FULL_CNT;
        end else begin
            return req;
        end
    endfunction

    assign first_s = (idx_r == {IDX_W{1'b0}});
    assign last_s  = (idx_r == (cnt_r - IDX_ONE));
    assign word_s  = {s_data, last_s, first_s, idx_r};

    // Next-state decode plus the combinational handshake/status outputs.
    always_comb begin
        state_nxt_s = state_r;
        s_ready     = 1'b0;
        busy        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                busy    = 1'b1;
                s_ready = !abort;
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (s_valid && last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            DONE: begin
                busy        = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        xfer_s = s_valid && s_ready;
    end

    // State, frame bookkeeping and the registered DMA word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= FULL_CNT;
            idx_r      <= {IDX_W{1'b0}};
            DMAport    <= IDLE_WORD;
            dma_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == IDLE) && start) begin
                cnt_r <= clamp_count(lane_count);
                idx_r <= {IDX_W{1'b0}};
            end else if (xfer_s && !last_s) begin
                idx_r <= idx_r + IDX_ONE;
            end
            if (xfer_s) begin
                DMAport   <= word_s;
                dma_valid <= 1'b1;
            end else begin
                DMAport   <= IDLE_WORD;
                dma_valid <= 1'b0;
            end
            frame_done <= (state_nxt_s == DONE);
            if (state_r == DONE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dma_lane_sequencer.sv
// Self-checking bench for dma_lane_sequencer: a directed vector table, hand-written
// frame sequences and random traffic against a frame-level reference model.
module tb_dma_lane_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  lane_count;
    logic        abort;
    logic        s_valid;
    logic [24:0] s_data;
    logic        s_ready;
    logic [31:0] DMAport;
    logic        dma_valid;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    dma_lane_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .lane_count(lane_count),
        .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .DMAport(DMAport), .dma_valid(dma_valid), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a frame is "in progress" with m_sent of m_total lanes delivered.
    bit          m_in_frame;
    bit          m_done_cycle;
    int          m_sent;
    int          m_total;
    logic [31:0] m_word;
    bit          m_valid;
    bit          m_done;
    logic [15:0] m_cnt;

    // Downstream lane demultiplexer fed by the DUT, plus write statistics.
    logic [24:0] lanes [18];
    int          writes;
    int          last_idx;

    task automatic model_reset();
        m_in_frame = 0; m_done_cycle = 0; m_sent = 0; m_total = 18;
        m_word = 32'h0000_001F; m_valid = 0; m_done = 0; m_cnt = 16'd0;
    endtask

    task automatic model_step(input logic r, input logic st, input logic [4:0] lc,
                              input logic ab, input logic sv, input logic [24:0] d);
        logic [31:0] nw;
        bit nv;
        bit nd;
        nw = 32'h0000_001F; nv = 0; nd = 0;
        if (r) begin
            model_reset();
            return;
        end
        if (m_done_cycle) begin
            m_cnt = m_cnt + 16'd1;
            m_done_cycle = 0;
        end else if (m_in_frame) begin
            if (ab) begin
                m_in_frame = 0;
            end else if (sv) begin
                nw = {d, 1'(m_sent == m_total - 1), 1'(m_sent == 0), 5'(m_sent)};
                nv = 1;
                m_sent++;
                if (m_sent == m_total) begin
                    m_in_frame = 0; m_done_cycle = 1; nd = 1;
                end
            end
        end else if (st) begin
            m_total = (lc == 5'd0 || lc > 5'd18) ? 18 : int'(lc);
            m_sent = 0;
            m_in_frame = 1;
        end
        m_word = nw; m_valid = nv; m_done = nd;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic [4:0] lc,
                         input logic ab, input logic sv, input logic [24:0] d);
        rst = r; start = st; lane_count = lc; abort = ab; s_valid = sv; s_data = d;
        #1;
    endtask

    task automatic sample();
        if (dma_valid === 1'b1) begin
            writes++;
            last_idx = int'(DMAport[4:0]);
            if (DMAport[4:0] < 5'd18) lanes[17 - int'(DMAport[4:0])] = DMAport[31:7];
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_step(rst, start, lane_count, abort, s_valid, s_data);
        @(negedge clk);
    endtask

    task automatic step(input logic st, input logic [4:0] lc, input logic ab,
                        input logic sv, input logic [24:0] d);
        drive(1'b0, st, lc, ab, sv, d);
        check("s_ready", {31'd0, s_ready}, {31'd0, 1'(m_in_frame && !ab)});
        check("busy", {31'd0, busy}, {31'd0, 1'(m_in_frame || m_done_cycle)});
        check("dma_valid", {31'd0, dma_valid}, {31'd0, m_valid});
        check("DMAport", DMAport, m_word);
        check("frame_done", {31'd0, frame_done}, {31'd0, m_done});
        check("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
        sample();
        finish_cycle();
    endtask

    task automatic run_frame(input logic [4:0] lc, input int data_cycles);
        step(1'b1, lc, 1'b0, 1'b0, 25'd0);
        for (int k = 0; k < data_cycles; k++) step(1'b0, 5'd0, 1'b0, 1'b1, 25'h100 + 25'(k));
    endtask

    typedef struct {
        logic        r, st;
        logic [4:0]  lc;
        logic        ab, sv;
        logic [24:0] d;
        logic        e_ready, e_busy, e_dv, e_fd;
        logic [31:0] e_word;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [12];

    localparam logic [24:0] PA = 25'h0ABC;
    localparam logic [24:0] PB = 25'h1_2345;
    localparam logic [24:0] PC = 25'h1FF_FFFF;

    initial begin
        // Reset, idle with s_valid, then a 3-lane frame with s_valid 1,0,0,1,0,1.
        tbl[0]  = '{1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 25'd0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_001F, 16'd0};
        tbl[1]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 25'h55,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_001F, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 5'd7, 1'b0, 1'b1, 25'h66,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_001F, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 25'd0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_001F, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b1, PA,      1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_001F, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 25'd0,   1'b1, 1'b1, 1'b1, 1'b0, {PA, 2'b01, 5'd0}, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 25'd0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_001F, 16'd0};
        tbl[7]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b1, PB,      1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_001F, 16'd0};
        tbl[8]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 25'd0,   1'b1, 1'b1, 1'b1, 1'b0, {PB, 2'b00, 5'd1}, 16'd0};
        tbl[9]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b1, PC,      1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_001F, 16'd0};
        tbl[10] = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 25'd9,   1'b0, 1'b1, 1'b1, 1'b1, {PC, 2'b10, 5'd2}, 16'd0};
        tbl[11] = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 25'd0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_001F, 16'd1};

        writes = 0; last_idx = -1;
        for (int j = 0; j < 18; j++) lanes[j] = 25'd0;
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 25'd0);
        model_reset();
        @(negedge clk);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].st, tbl[i].lc, tbl[i].ab, tbl[i].sv, tbl[i].d);
            check($sformatf("tbl%0d_s_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].e_ready});
            check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
            check($sformatf("tbl%0d_dma_valid", i), {31'd0, dma_valid}, {31'd0, tbl[i].e_dv});
            check($sformatf("tbl%0d_frame_done", i), {31'd0, frame_done}, {31'd0, tbl[i].e_fd});
            check($sformatf("tbl%0d_DMAport", i), DMAport, tbl[i].e_word);
            check($sformatf("tbl%0d_frame_cnt", i), {16'd0, frame_cnt}, {16'd0, tbl[i].e_cnt});
            sample();
            finish_cycle();
        end
        check("short_writes", 32'(writes), 32'd3);

        // Full frame of 18 lanes loads demux lanes 17..0 in order.
        writes = 0;
        run_frame(5'd18, 18);
        step(1'b0, 5'd0, 1'b0, 1'b1, 25'h7);
        step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);
        check("full_writes", 32'(writes), 32'd18);
        for (int j = 0; j < 18; j++)
            check($sformatf("lane%0d", j), {7'd0, lanes[j]}, 32'h100 + 32'(17 - j));

        // Clamp of 0 and of an over-range count to a full frame.
        for (int c = 0; c < 2; c++) begin
            writes = 0; last_idx = -1;
            run_frame((c == 0) ? 5'd0 : 5'd25, 21);
            step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);
            check($sformatf("clamp%0d_writes", c), 32'(writes), 32'd18);
            check($sformatf("clamp%0d_last_idx", c), 32'(last_idx), 32'd17);
        end

        // Abort together with the sixth valid payload.
        writes = 0;
        run_frame(5'd18, 5);
        step(1'b0, 5'd0, 1'b1, 1'b1, 25'h1AB);
        step(1'b0, 5'd0, 1'b0, 1'b1, 25'h1AC);
        step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);
        check("abort_writes", 32'(writes), 32'd5);
        check("abort_last_idx", 32'(last_idx), 32'd4);
        run_frame(5'd2, 2);
        step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);

        // A start pulse mid-frame is ignored.
        writes = 0;
        run_frame(5'd6, 3);
        step(1'b1, 5'd2, 1'b0, 1'b1, 25'h3);
        step(1'b0, 5'd0, 1'b0, 1'b1, 25'h4);
        step(1'b0, 5'd0, 1'b0, 1'b1, 25'h5);
        step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);
        step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);
        check("restart_ignored_writes", 32'(writes), 32'd6);
        check("restart_ignored_last_idx", 32'(last_idx), 32'd5);

        // Counter wrap: preload near the top, then complete two frames.
        force dut.frame_cnt = 16'hFFFE;
        m_cnt = 16'hFFFE;
        step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);
        release dut.frame_cnt;
        run_frame(5'd1, 1);
        step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);
        step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);
        check("cnt_ffff", {16'd0, frame_cnt}, 32'h0000_FFFF);
        run_frame(5'd1, 1);
        step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);
        step(1'b0, 5'd0, 1'b0, 1'b0, 25'h0);
        check("cnt_wrap", {16'd0, frame_cnt}, 32'h0000_0000);

        // Random traffic including occasional aborts and resets.
        for (int n = 0; n < 2000; n++) begin
            logic r;
            r = ($urandom_range(0, 249) == 0);
            if (r) begin
                drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 25'd0);
                sample();
                finish_cycle();
            end else begin
                step(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                     ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0),
                     25'($urandom));
            end
        end

        // Mid-frame reset returns everything to reset values.
        run_frame(5'd10, 4);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 25'h5);
        finish_cycle();
        step(1'b0, 5'd0, 1'b0, 1'b1, 25'h6);
        check("post_reset_word", DMAport, 32'h0000_001F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_lane_sequencer.md
# dma_lane_sequencer

Sequences a stream of 25-bit lane payloads into the accelerator's 32-bit DMA port word format. Each word carries the payload in [31:7], frame tags in [6:5] and a lane index in [4:0]. The downstream lane demultiplexer routes index k to lane output 17−k, and any index ≥18 writes no lane. The block sits between the DMA source (valid/ready stream) and that demultiplexer. It loads one frame of up to 18 lanes per start command, so lanes are always written in index order with no gaps.

## Interface
Parameters:
- NUM_LANES, 18, lanes per full frame (index range 0..NUM_LANES−1)
- PAY_W, 25, payload width (DMAport[31:7])
- IDX_W, 5, lane index width (DMAport[4:0])

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- lane_count  in  5  lanes to load this frame; latched with start; 0 or >NUM_LANES clamps to NUM_LANES
- abort  in  1  cancel frame in progress; sampled in STREAM only
- s_valid  in  1  source payload valid
- s_data  in  25  source payload
- s_ready  out  1  sequencer accepts payload this cycle
- DMAport  out  32  registered word to lane demultiplexer
- dma_valid  out  1  DMAport holds a real lane write this cycle
- busy  out  1  high in STREAM and DONE
- frame_done  out  1  one-cycle pulse on frame completion
- frame_cnt  out  16  completed frames, wraps 0xFFFF→0

## Operation
- States: IDLE, STREAM, DONE. Reset → IDLE.
- Idle word: 32'h0000_001F (payload 0, tags 00, index 31). DMAport holds the idle word whenever dma_valid=0, so the demultiplexer never writes a lane.
- IDLE: s_ready=0. If start=1: latch the clamped count into cnt_q, idx←0, go to STREAM. Otherwise stay.
- STREAM: s_ready=1. A transfer happens when s_valid&&s_ready.
  - On a transfer, register DMAport ← {s_data, last, first, idx} and set dma_valid←1.
  - first (bit 5) = (idx==0). last (bit 6) = (idx==cnt_q−1).
  - On a transfer with last=1, go to DONE. Otherwise idx←idx+1.
  - With no transfer, DMAport←idle word and dma_valid←0.
- DONE: a single cycle. frame_done=1, frame_cnt←frame_cnt+1, then IDLE. s_ready=0.
- abort=1 in STREAM:
  - Go to IDLE next edge. No frame_done, frame_cnt unchanged.
  - A payload presented in that cycle is not accepted: s_ready is forced to 0 when abort=1.
  - DMAport←idle word.
- start in STREAM or DONE is ignored and not queued. abort in IDLE or DONE is ignored.
- Priority in STREAM: rst > abort > transfer.
- lane_count and s_data are not required stable outside their sampling cycles.

## Timing
- Reset values: state IDLE, DMAport=32'h0000_001F, dma_valid=0, s_ready=0, busy=0, frame_done=0, frame_cnt=0, idx=0, cnt_q=NUM_LANES.
- Reset mid-frame takes effect at the next edge. All outputs return to reset values. The partial frame is dropped and the downstream lanes written so far are not cleared.
- s_ready and busy are decoded combinationally from the registered state (s_ready additionally gated by abort). DMAport, dma_valid, frame_done and frame_cnt are registered.
- Start sampled at edge t: STREAM from t+1, s_ready high during cycle t+1.
- Latency: a payload accepted at edge k appears on DMAport/dma_valid during cycle k+1 for exactly one cycle.
- Minimum frame of N lanes with s_valid held high: start edge t, transfers at edges t+1..t+N, DONE during cycle t+N+1, frame_done high that cycle, IDLE from t+N+2. A new start is accepted at edge t+N+2, giving N+2 cycles per frame.
- s_valid gaps stall idx; no timeout.

## Test plan
- Reset: hold rst 2 cycles → DMAport=32'h0000_001F, all flags 0, frame_cnt=0. Then s_valid=1 with no start → s_ready stays 0 and no dma_valid.
- Full frame: start with lane_count=18, s_data=lane number+0x100, s_valid held → 18 consecutive dma_valid cycles with DMAport[4:0]=0..17 and payload 0x100..0x111. Bit 5 set only on the first word, bit 6 only on the last. frame_done one cycle later, frame_cnt=1, demux lanes 17..0 loaded.
- Short frame with gaps: lane_count=3, s_valid toggling 1,0,0,1,0,1 → exactly 3 writes with indices 0,1,2. DMAport shows the idle word in gap cycles. frame_done follows the third write.
- Clamp: lane_count=0, then lane_count=25 → each frame completes after 18 writes, last index 17.
- Abort: lane_count=18, abort asserted in the same cycle the 6th payload is valid → 5 writes only (indices 0..4), IDLE next edge, no frame_done, frame_cnt unchanged. A new start restarts at index 0.
- Ignored start and counter wrap: pulse start mid-STREAM → no restart and indices continue. Preload by running frames until frame_cnt=0xFFFF, complete one more → frame_cnt=0.
